// File: rtl/mfp_uart_srec_loader_if.sv
// Byte-stream input and word-write output bundle of the S-record loader.
// The master side is the UART/host, the slave side is the loader itself.
interface mfp_uart_srec_loader_if #(
  parameter int record_count_width = 16
);
  logic [7:0]                    byte_data;
  logic                          byte_ready;
  logic                          error_clear;
  logic                          write_enable;
  logic [31:0]                   write_address;
  logic [31:0]                   write_data;
  logic                          record_active;
  logic                          format_error;
  logic                          checksum_error;
  logic [record_count_width-1:0] record_count;

  modport master (
    output byte_data, byte_ready, error_clear,
    input  write_enable, write_address, write_data, record_active,
    input  format_error, checksum_error, record_count
  );

  modport slave (
    input  byte_data, byte_ready, error_clear,
    output write_enable, write_address, write_data, record_active,
    output format_error, checksum_error, record_count
  );
endinterface

// File: rtl/mfp_uart_srec_loader.sv
// Motorola S3-record parser that turns a UART character stream into
// little-endian 32-bit word writes for the program-load path.
module mfp_uart_srec_loader #(
  parameter int record_count_width = 16,
  parameter bit accept_lowercase   = 1'b1
) (
  input logic                  clock,
  input logic                  reset_n,
  mfp_uart_srec_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    COUNT,
    ADDR,
    DATA,
    CSUM,
    SKIP
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [2:0]                    nib_cnt;
  logic [3:0]                    hi_nib;
  logic [7:0]                    count_q;
  logic [7:0]                    sum_q;
  logic [7:0]                    data_left;
  logic [31:0]                   addr_q;
  logic [31:0]                   word_q;
  logic [1:0]                    byte_idx;
  logic                          write_enable_q;
  logic [31:0]                   write_address_q;
  logic [31:0]                   write_data_q;
  logic                          format_error_q;
  logic                          checksum_error_q;
  logic [record_count_width-1:0] record_count_q;

  logic                          hex_ok;
  logic [3:0]                    hex_val;
  logic [7:0]                    field_byte;
  logic [7:0]                    addr_byte;
  logic [7:0]                    sum_inv;
  logic                          set_format;
  logic                          set_checksum;
  logic                          record_good;

  always_comb begin
    hex_ok  = 1'b0;
    hex_val = 4'd0;
    if (bus.byte_data >= 8'h30 && bus.byte_data <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_val = bus.byte_data[3:0];
    end else if (bus.byte_data >= 8'h41 && bus.byte_data <= 8'h46) begin
      hex_ok  = 1'b1;
      hex_val = bus.byte_data[3:0] + 4'd9;
    end else if (accept_lowercase && bus.byte_data >= 8'h61 && bus.byte_data <= 8'h66) begin
      hex_ok  = 1'b1;
      hex_val = bus.byte_data[3:0] + 4'd9;
    end
  end

  assign field_byte = {hi_nib, hex_val};
  assign addr_byte  = {addr_q[3:0], hex_val};
  assign sum_inv    = ~sum_q;

  // A count of 5 + 4n bytes is the only shape that yields whole words.
  always_comb begin
    state_next   = state;
    set_format   = 1'b0;
    set_checksum = 1'b0;
    record_good  = 1'b0;
    if (bus.byte_ready) begin
      case (state)
        IDLE: begin
          if (bus.byte_data == 8'h53) state_next = TYPE;
        end
        TYPE: begin
          state_next = (bus.byte_data == 8'h33) ? COUNT : SKIP;
        end
        COUNT: begin
          if (!hex_ok) begin
            set_format = 1'b1;
            state_next = SKIP;
          end else if (nib_cnt[0]) begin
            if (field_byte < 8'd5 || field_byte[1:0] != 2'b01) begin
              set_format = 1'b1;
              state_next = SKIP;
            end else begin
              state_next = ADDR;
            end
          end
        end
        ADDR: begin
          if (!hex_ok) begin
            set_format = 1'b1;
            state_next = SKIP;
          end else if (nib_cnt == 3'd7) begin
            if (hex_val[1:0] != 2'b00) begin
              set_format = 1'b1;
              state_next = SKIP;
            end else if (count_q == 8'd5) begin
              state_next = CSUM;
            end else begin
              state_next = DATA;
            end
          end
        end
        DATA: begin
          if (!hex_ok) begin
            set_format = 1'b1;
            state_next = SKIP;
          end else if (nib_cnt[0] && data_left == 8'd1) begin
            state_next = CSUM;
          end
        end
        CSUM: begin
          if (!hex_ok) begin
            set_format = 1'b1;
            state_next = SKIP;
          end else if (nib_cnt[0]) begin
            if (field_byte == sum_inv) record_good = 1'b1;
            else set_checksum = 1'b1;
            state_next = IDLE;
          end
        end
        SKIP: begin
          if (bus.byte_data == 8'h0D || bus.byte_data == 8'h0A) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Words are written as soon as they complete; the checksum only flags the record afterwards.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= IDLE;
      nib_cnt          <= 3'd0;
      hi_nib           <= 4'd0;
      count_q          <= 8'd0;
      sum_q            <= 8'd0;
      data_left        <= 8'd0;
      addr_q           <= 32'd0;
      word_q           <= 32'd0;
      byte_idx         <= 2'd0;
      write_enable_q   <= 1'b0;
      write_address_q  <= 32'd0;
      write_data_q     <= 32'd0;
      format_error_q   <= 1'b0;
      checksum_error_q <= 1'b0;
      record_count_q   <= '0;
    end else begin
      state          <= state_next;
      write_enable_q <= 1'b0;

      if (set_format) format_error_q <= 1'b1;
      else if (bus.error_clear) format_error_q <= 1'b0;

      if (set_checksum) checksum_error_q <= 1'b1;
      else if (bus.error_clear) checksum_error_q <= 1'b0;

      if (record_good)
        record_count_q <= record_count_q + {{(record_count_width-1){1'b0}}, 1'b1};

      if (bus.byte_ready) begin
        nib_cnt <= (state_next != state) ? 3'd0 : nib_cnt + 3'd1;
        case (state)
          TYPE: begin
            byte_idx <= 2'd0;
          end
          COUNT: begin
            hi_nib <= hex_val;
            if (nib_cnt[0]) begin
              count_q   <= field_byte;
              sum_q     <= field_byte;
              data_left <= field_byte - 8'd5;
            end
          end
          ADDR: begin
            addr_q <= {addr_q[27:0], hex_val};
            if (nib_cnt[0]) sum_q <= sum_q + addr_byte;
          end
          DATA: begin
            hi_nib <= hex_val;
            if (nib_cnt[0] && hex_ok) begin
              sum_q                          <= sum_q + field_byte;
              data_left                      <= data_left - 8'd1;
              word_q[{byte_idx, 3'b000} +: 8] <= field_byte;
              byte_idx                       <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                write_enable_q  <= 1'b1;
                write_address_q <= addr_q;
                write_data_q    <= {field_byte, word_q[23:0]};
                addr_q          <= addr_q + 32'd4;
              end
            end
          end
          CSUM: begin
            hi_nib <= hex_val;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.write_enable   = write_enable_q;
  assign bus.write_address  = write_address_q;
  assign bus.write_data     = write_data_q;
  assign bus.record_active  = (state == COUNT) || (state == ADDR) ||
                              (state == DATA)  || (state == CSUM);
  assign bus.format_error   = format_error_q;
  assign bus.checksum_error = checksum_error_q;
  assign bus.record_count   = record_count_q;

endmodule
